cop_responder: RTL

Coprocessor-side endpoint of the CPU coprocessor interface. Samples the CPU's GO/OP/operand bundle and runs a multi-cycle arithmetic operation. Returns a 64-bit result with a one-cycle done pulse, which drives the CPU's COP_DONE/COP_IN inputs. Replaces the ad-hoc done/result sources currently tied to those CPU inputs in the top level.

---
 rtl/cop_pkg.sv | 27 ++
 rtl/cop_mul32.sv | 58 +++++
 rtl/cop_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cop_pkg.sv
// cop_pkg: shared constants for the coprocessor responder.
// Function codes, FSM states, cop_op field positions, latencies.
package cop_pkg;

  localparam logic [7:0] FN_ADD  = 8'h00;
  localparam logic [7:0] FN_XOR  = 8'h01;
  localparam logic [7:0] FN_ROTL = 8'h02;
  localparam logic [7:0] FN_MUL  = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam int OP_ID_HI = 23;
  localparam int OP_ID_LO = 16;
  localparam int OP_R_HI  = 13;
  localparam int OP_R_LO  = 8;
  localparam int OP_FN_HI = 7;
  localparam int OP_FN_LO = 0;

  localparam int LAT_BASE  = 2;
  localparam int LAT_MUL   = 34;
  localparam int MUL_STEPS = 32;

endpackage

// File: rtl/cop_mul32.sv
// cop_mul32: iterative radix-2 shift-add 32x32 multiplier.
// One step per cycle after i_start; o_done pulses with the product.
module cop_mul32
  import cop_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [63:0] o_p
);

  logic [31:0] r_a;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [32:0] w_sum;

  // {r_hi, r_lo} shifts right; r_lo starts as the multiplier
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a    <= i_a;
        r_hi   <= '0;
        r_lo   <= i_b;
        r_cnt  <= 5'(MUL_STEPS - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_hi <= w_sum[32:1];
        r_lo <= {w_sum[0], r_lo[31:1]};
        if (r_cnt == 5'd0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 5'd1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_p    = {r_hi, r_lo};

endmodule

// File: rtl/cop_responder.sv
// cop_responder: coprocessor endpoint for the CPU GO/OP bundle.
// Executes ADD/XOR/ROTL/MUL and returns a registered 64-bit result.
module cop_responder
  import cop_pkg::*;
#(
  parameter logic [7:0] COP_ID = 8'h00,
  parameter bit         MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cop_go,
  input  logic [23:0]  cop_op,
  input  logic [127:0] cop_out,
  output logic         cop_done,
  output logic [63:0]  cop_in,
  output logic         busy,
  output logic         err,
  output logic         ovr
);

  state_t      r_state;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic [7:0]  r_fn;
  logic [5:0]  r_cnt;
  logic [63:0] r_res;
  logic        r_done;
  logic        r_busy;
  logic        r_err;
  logic        r_ovr;

  logic        w_hit;
  logic        w_mul_start;
  logic        w_mul_done;
  logic [63:0] w_mul_p;
  logic        w_wait_mul;
  logic        w_fin;
  logic        w_legal;
  logic [63:0] w_res;
  logic        w_unused;

  assign w_unused = ^cop_op[15:14];

  assign w_hit = cop_go && (cop_op[OP_ID_HI:OP_ID_LO] == COP_ID);
  assign w_mul_start = MUL_EN && (r_state == IDLE) && w_hit
                    && (cop_op[OP_FN_HI:OP_FN_LO] == FN_MUL);
  assign w_wait_mul = MUL_EN && (r_fn == FN_MUL);
  assign w_fin = w_wait_mul ? w_mul_done : (r_cnt == 6'd0);

  if (MUL_EN) begin : g_mul
    cop_mul32 u_mul (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_mul_start),
      .i_a     (cop_out[31:0]),
      .i_b     (cop_out[95:64]),
      .o_done  (w_mul_done),
      .o_p     (w_mul_p)
    );
  end else begin : g_nomul
    assign w_mul_done = 1'b0;
    assign w_mul_p    = '0;
  end

  // ROTL result is r_a itself: it is rotated in place during EXEC
  always_comb begin
    w_legal = 1'b1;
    w_res   = '0;
    case (r_fn)
      FN_ADD:  w_res = r_a + r_b;
      FN_XOR:  w_res = r_a ^ r_b;
      FN_ROTL: w_res = r_a;
      FN_MUL: begin
        w_res   = w_mul_p;
        w_legal = MUL_EN;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_fn    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (cop_go && (r_state != IDLE))
        r_ovr <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_a    <= cop_out[63:0];
            r_b    <= cop_out[127:64];
            r_fn   <= cop_op[OP_FN_HI:OP_FN_LO];
            r_cnt  <= (cop_op[OP_FN_HI:OP_FN_LO] == FN_ROTL)
                    ? cop_op[OP_R_HI:OP_R_LO] : 6'd0;
            r_busy <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_fin) begin
            r_res   <= w_legal ? w_res : 64'h0;
            r_done  <= 1'b1;
            r_err   <= ~w_legal;
            r_state <= DONE;
          end else if (!w_wait_mul) begin
            r_a   <= {r_a[62:0], r_a[63]};
            r_cnt <= r_cnt - 6'd1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cop_done = r_done;
  assign cop_in   = r_res;
  assign busy     = r_busy;
  assign err      = r_err;
  assign ovr      = r_ovr;

endmodule
